// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - register offsets within the 256-byte window
//   - STATUS bit positions
//   - transmit FSM state type
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits
// and widens the state type to 3 bits.
package uart_pkg;

    localparam logic [7:0] UART_REG_DATA   = 8'h00;
    localparam logic [7:0] UART_REG_STATUS = 8'h04;
    localparam logic [7:0] UART_REG_DIV    = 8'h08;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_PARITY  = 4;
    localparam int unsigned STAT_CNT_LSB = 8;
    localparam int unsigned STAT_CNT_W   = 9;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop
    } uart_state_e;
`else
    localparam bit PARITY_EN = 1'b0;
    typedef enum logic [1:0] {
        StIdle, StStart, StData, StStop
    } uart_state_e;
`endif

    // A divisor of 0 would make the bit period undefined; it is stored as 1.
    function automatic logic [15:0] sanitize_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for transmission.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   push, wdata        write request and data (ignored when full unless popping too)
//   pop                read request (ignored when empty)
//   rdata              head entry, valid while !empty
//   full, empty, cnt   occupancy flags and entry count (0..DEPTH)
// DEPTH must be a power of two between 2 and 256 so pointers wrap naturally.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign cnt     = cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native memory bus.
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb         CPU bus request (wstrb == 0 is a read)
//   uart_sel                           combinational window hit
//   uart_ready                         one-cycle transaction-complete pulse
//   uart_rdata                         read data, zero outside the ready pulse
//   uart_tx                            serial line, idle high, LSB first
// Registers: 0x00 DATA (push byte), 0x04 STATUS, 0x08 DIV (clock cycles per bit).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter logic [31:0]  ADDR        = 32'h5000_0000,
    parameter int unsigned  FIFO_DEPTH  = 8,
    parameter logic [15:0]  DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        uart_sel,
    output logic        uart_ready,
    output logic [31:0] uart_rdata,
    output logic        uart_tx
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Bus side
    logic        sel_q;
    logic        access, is_write;
    logic [7:0]  offset;
    logic        ready_q;
    logic [31:0] rdata_q, rd_val, status;
    logic        ovf_q;
    logic [15:0] div_q, div_new;
    logic        wr_data, wr_stat_clr, wr_div;
    logic        unused_wdata;

    // FIFO
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_cnt;

    // Transmit FSM
    uart_state_e state_q, state_d;
    logic [15:0] bc_q, bc_d;
    logic [15:0] div_l_q, div_l_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sr_q, sr_d;
    logic        tx_q, tx_d;
    logic        bit_done;

    assign uart_sel = mem_valid && (mem_addr[31:8] == ADDR[31:8]);
    // A transaction starts only on the first selected cycle; a master holding valid past
    // ready does not retrigger until sel has dropped for at least one cycle.
    assign access   = uart_sel && !sel_q;
    assign is_write = (mem_wstrb != 4'b0000);
    assign offset   = mem_addr[7:0];

    assign unused_wdata = ^mem_wdata[31:16];

    assign wr_data     = access && is_write && (offset == UART_REG_DATA) && mem_wstrb[0];
    assign wr_stat_clr = access && is_write && (offset == UART_REG_STATUS) && mem_wstrb[0]
                         && mem_wdata[3];
    assign wr_div      = access && is_write && (offset == UART_REG_DIV)
                         && (mem_wstrb[1:0] != 2'b00);
    assign div_new     = {mem_wstrb[1] ? mem_wdata[15:8] : div_q[15:8],
                          mem_wstrb[0] ? mem_wdata[7:0]  : div_q[7:0]};
    assign push        = wr_data;

    always_comb begin
        status                                = '0;
        status[STAT_FULL]                     = fifo_full;
        status[STAT_EMPTY]                    = fifo_empty;
        status[STAT_BUSY]                     = (state_q != StIdle);
        status[STAT_OVF]                      = ovf_q;
        status[STAT_PARITY]                   = PARITY_EN;
        status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_cnt);
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            UART_REG_STATUS: rd_val = status;
            UART_REG_DIV:    rd_val = {16'b0, div_q};
            default:         rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            div_q   <= sanitize_div(DEFAULT_DIV);
        end else begin
            sel_q   <= uart_sel;
            ready_q <= access;
            rdata_q <= (access && !is_write) ? rd_val : '0;
            // Drop only when no pop frees a slot this cycle.
            if (wr_data && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end else if (wr_stat_clr) begin
                ovf_q <= 1'b0;
            end
            if (wr_div) div_q <= sanitize_div(div_new);
        end
    end

    assign uart_ready = ready_q;
    assign uart_rdata = rdata_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (mem_wdata[7:0]),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .cnt    (fifo_cnt)
    );

    assign bit_done = (bc_q == 16'd0);

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        div_l_d = div_l_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        pop     = 1'b0;
        // Every non-idle state lasts div_l cycles: reload on expiry, else count down.
        if (state_q != StIdle) begin
            bc_d = bit_done ? (div_l_q - 16'd1) : (bc_q - 16'd1);
        end
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sr_d    = fifo_rdata;
                    div_l_d = div_q;      // divisor frozen for the whole frame
                    bc_d    = div_q - 16'd1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    idx_d   = 3'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Line level is registered from the next state so uart_tx is glitch-free.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = sr_d[idx_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = ^sr_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            bc_q    <= '0;
            div_l_q <= 16'd1;
            idx_q   <= '0;
            sr_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            div_l_q <= div_l_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            tx_q    <= tx_d;
        end
    end

    assign uart_tx = tx_q;

endmodule
